// File: rtl/press_classifier.sv
// Classifies a debounced button level into press, long-press, auto-repeat and
// release pulses. Define AUTO_REPEAT_EN to enable the auto-repeat feature.
module press_classifier #(
  parameter int unsigned LONG_CYCLES   = 25000000,
  parameter int unsigned REPEAT_CYCLES = 10000000,
  parameter int unsigned CNT_W         = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic flap_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic release_pulse,
  output logic held
);

  if (LONG_CYCLES < 1 || longint'(LONG_CYCLES) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_long
    $error("LONG_CYCLES out of range for CNT_W");
  end
  if (REPEAT_CYCLES < 1 || longint'(REPEAT_CYCLES) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_repeat
    $error("REPEAT_CYCLES out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    LONG
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             btn_q;
  logic             rise;
  logic             flap_nxt, long_nxt, release_nxt;

  assign rise = btn_in & ~btn_q;

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic repeat_nxt;
`endif

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    flap_nxt    = 1'b0;
    long_nxt    = 1'b0;
    release_nxt = 1'b0;
`ifdef AUTO_REPEAT_EN
    repeat_nxt  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = PRESS;
          cnt_nxt   = '0;
          flap_nxt  = 1'b1;
        end
      end
      PRESS: begin
        // Release is tested first so it wins over a coincident long threshold.
        if (!btn_in) begin
          state_nxt   = IDLE;
          cnt_nxt     = '0;
          release_nxt = 1'b1;
        end else if (cnt == LONG_LAST) begin
          state_nxt = LONG;
          cnt_nxt   = '0;
          long_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      LONG: begin
        if (!btn_in) begin
          state_nxt   = IDLE;
          cnt_nxt     = '0;
          release_nxt = 1'b1;
        end else begin
`ifdef AUTO_REPEAT_EN
          if (cnt == REPEAT_LAST) begin
            cnt_nxt    = '0;
            repeat_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
`else
          cnt_nxt = '0;
`endif
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // btn_q resets high so a button already held at reset release is not a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      btn_q         <= 1'b1;
      flap_pulse    <= 1'b0;
      long_pulse    <= 1'b0;
      release_pulse <= 1'b0;
      held          <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      btn_q         <= btn_in;
      flap_pulse    <= flap_nxt;
      long_pulse    <= long_nxt;
      release_pulse <= release_nxt;
      held          <= (state_nxt != IDLE);
    end
  end

`ifdef AUTO_REPEAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      repeat_pulse <= 1'b0;
    end else begin
      repeat_pulse <= repeat_nxt;
    end
  end
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_press_classifier.sv
// Randomized and directed bench for press_classifier against a hold-length
// reference model; honours AUTO_REPEAT_EN when defined for the build.
module tb_press_classifier;

  localparam int LONG   = 4;
  localparam int REPEAT = 3;
`ifdef AUTO_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk, rst, btn_in;
  logic flap_pulse, long_pulse, repeat_pulse, release_pulse, held;
  logic [4:0] obs;

  press_classifier #(
    .LONG_CYCLES  (LONG),
    .REPEAT_CYCLES(REPEAT),
    .CNT_W        (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_in       (btn_in),
    .flap_pulse   (flap_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .release_pulse(release_pulse),
    .held         (held)
  );

  assign obs = {flap_pulse, long_pulse, repeat_pulse, release_pulse, held};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: a press is tracked from its rising sample; m_run counts the
  // held cycles since the flap pulse. Vector is {flap,long,repeat,release,held}.
  bit         m_tracked;
  bit         m_prev;
  int         m_run;
  logic [4:0] exp;

  task automatic model_reset();
    m_tracked = 1'b0;
    m_prev    = 1'b1;
    m_run     = 0;
    exp       = '0;
  endtask

  task automatic model_step(input logic b);
    exp = '0;
    if (rst) begin
      model_reset();
    end else begin
      if (!m_tracked) begin
        if (b && !m_prev) begin
          m_tracked = 1'b1;
          m_run     = 0;
          exp[4]    = 1'b1;
        end
      end else if (!b) begin
        m_tracked = 1'b0;
        exp[1]    = 1'b1;
      end else begin
        m_run++;
        if (m_run == LONG) exp[3] = 1'b1;
        else if (REP_EN && m_run > LONG && (m_run - LONG) % REPEAT == 0) exp[2] = 1'b1;
      end
      m_prev = b;
      exp[0] = m_tracked;
    end
  endtask

  task automatic cycle(input logic b);
    btn_in = b;
    @(posedge clk);
    model_step(b);
    #1;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    btn_in = 1'b0;
    model_reset();
    #2;
    n_checks++;
    if (obs !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_async: got %b want %b", obs, 5'b0);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL reset_hold cyc %0d: got %b want %b", i, obs, exp);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL reset_exit cyc %0d: got %b want %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_short_press();
    logic seq [0:5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    int flap_at = -1, rel_at = -1, long_seen = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(seq[i]);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL short_press cyc %0d: got %b want %b", i + 1, obs, exp);
      end
      if (flap_pulse && flap_at < 0) flap_at = i + 1;
      if (release_pulse && rel_at < 0) rel_at = i + 1;
      if (long_pulse) long_seen++;
    end
    n_checks++;
    if (flap_at != 1 || rel_at != 3 || long_seen != 0) begin
      n_fail++;
      $display("FAIL short_press_timing: flap@%0d rel@%0d longs %0d want 1 3 0", flap_at, rel_at, long_seen);
    end
  endtask

  task automatic test_long_hold();
    int long_at = -1, flap_at = -1, rep_first = -1, rep_cnt = 0, rel_at = -1;
    for (int i = 0; i < 15; i++) begin
      cycle(i < 12);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL long_hold cyc %0d: got %b want %b", i + 1, obs, exp);
      end
      if (flap_pulse && flap_at < 0) flap_at = i + 1;
      if (long_pulse && long_at < 0) long_at = i + 1;
      if (repeat_pulse) begin
        rep_cnt++;
        if (rep_first < 0) rep_first = i + 1;
      end
      if (release_pulse && rel_at < 0) rel_at = i + 1;
    end
    n_checks++;
    if (flap_at != 1 || long_at != 5 || rel_at != 13) begin
      n_fail++;
      $display("FAIL long_hold_timing: flap@%0d long@%0d rel@%0d want 1 5 13", flap_at, long_at, rel_at);
    end
    n_checks++;
    if (rep_cnt != (REP_EN ? 2 : 0) || (REP_EN && rep_first != 8)) begin
      n_fail++;
      $display("FAIL long_hold_repeat: count %0d first@%0d want %0d first@8", rep_cnt, rep_first, REP_EN ? 2 : 0);
    end
  endtask

  task automatic test_release_at_threshold();
    int long_seen = 0, rel_at = -1;
    for (int i = 0; i < 7; i++) begin
      cycle(i < 4);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL release_at_threshold cyc %0d: got %b want %b", i + 1, obs, exp);
      end
      if (long_pulse) long_seen++;
      if (release_pulse && rel_at < 0) rel_at = i + 1;
    end
    n_checks++;
    if (long_seen != 0 || rel_at != 5) begin
      n_fail++;
      $display("FAIL release_priority: longs %0d rel@%0d want 0 5", long_seen, rel_at);
    end
  endtask

  task automatic test_reset_while_high();
    int flaps = 0;
    for (int i = 0; i < 3; i++) cycle(1'b1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (obs !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_high_async: got %b want %b", obs, 5'b0);
    end
    for (int i = 0; i < 2; i++) cycle(1'b1);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL reset_high_hold cyc %0d: got %b want %b", i, obs, exp);
      end
      if (flap_pulse) flaps++;
    end
    n_checks++;
    if (flaps != 0) begin
      n_fail++;
      $display("FAIL reset_high_no_flap: flaps %0d want 0", flaps);
    end
    cycle(1'b0);
    cycle(1'b1);
    n_checks++;
    if (obs !== 5'b10001) begin
      n_fail++;
      $display("FAIL reset_high_repress: got %b want %b", obs, 5'b10001);
    end
    cycle(1'b0);
    cycle(1'b0);
  endtask

  task automatic test_reset_mid_long();
    int rels = 0;
    for (int i = 0; i < 7; i++) cycle(1'b1);
    n_checks++;
    if (held !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_long_held: got %b want 1", held);
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (obs !== 5'b0) begin
      n_fail++;
      $display("FAIL mid_long_async: got %b want %b", obs, 5'b0);
    end
    cycle(1'b0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL mid_long_after cyc %0d: got %b want %b", i, obs, exp);
      end
      if (release_pulse) rels++;
    end
    n_checks++;
    if (rels != 0) begin
      n_fail++;
      $display("FAIL mid_long_no_release: releases %0d want 0", rels);
    end
  endtask

  task automatic test_back_to_back();
    logic seq [0:7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    int flaps = 0, rels_between = 0, rels = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(seq[i]);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL back_to_back cyc %0d: got %b want %b", i + 1, obs, exp);
      end
      if (flap_pulse) flaps++;
      if (release_pulse) begin
        rels++;
        if (flaps == 1) rels_between++;
      end
    end
    n_checks++;
    if (flaps != 2 || rels_between != 1 || rels != 2) begin
      n_fail++;
      $display("FAIL back_to_back_counts: flaps %0d between %0d rels %0d want 2 1 2", flaps, rels_between, rels);
    end
  endtask

  task automatic test_random();
    for (int burst = 0; burst < 60; burst++) begin
      int hi = $urandom_range(1, 14);
      int lo = $urandom_range(1, 3);
      for (int i = 0; i < hi + lo; i++) begin
        cycle(i < hi);
        n_checks++;
        if (obs !== exp) begin
          n_fail++;
          $display("FAIL random b%0d cyc %0d: got %b want %b", burst, i, obs, exp);
        end
      end
      if ($urandom_range(0, 14) == 0) begin
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (obs !== 5'b0) begin
          n_fail++;
          $display("FAIL random_reset b%0d: got %b want %b", burst, obs, 5'b0);
        end
        cycle(1'($urandom_range(0, 1)));
        rst = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_long_hold();
    test_release_at_threshold();
    test_reset_while_high();
    test_reset_mid_long();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/press_classifier.md
PRESS_CLASSIFIER -- requirements
Module: press_classifier

Interface
REQ-001 SHALL have parameter LONG_CYCLES, default 25000000, cycles of continuous hold before a long press; legal range 1 to 2^CNT_W-1.
REQ-002 SHALL have parameter REPEAT_CYCLES, default 10000000, auto-repeat period in cycles; legal range 1 to 2^CNT_W-1.
REQ-003 SHALL have parameter CNT_W, default 32, hold-counter width in bits.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port btn_in, input, 1, debounced button level, synchronous to clk.
REQ-007 SHALL have port flap_pulse, output, 1, one-cycle pulse on each new press.
REQ-008 SHALL have port long_pulse, output, 1, one-cycle pulse when a press reaches LONG_CYCLES.
REQ-009 SHALL have port repeat_pulse, output, 1, one-cycle pulse per auto-repeat period.
REQ-010 SHALL have port release_pulse, output, 1, one-cycle pulse when a tracked press ends.
REQ-011 SHALL have port held, output, 1, high while the FSM is in PRESS or LONG.

Function
REQ-012 SHALL register btn_in into btn_q every cycle; rise = btn_in & ~btn_q.
REQ-013 SHALL implement FSM states IDLE, PRESS and LONG; all outputs registered.
REQ-014 SHALL, in IDLE with rise, go to PRESS, clear cnt and pulse flap_pulse in the next cycle (1-cycle latency from first high sample).
REQ-015 SHALL, in IDLE with btn_in high and no rise, stay in IDLE with no pulses.
REQ-016 SHALL, in PRESS with btn_in high, increment cnt each cycle.
REQ-017 SHALL, when cnt == LONG_CYCLES-1 in PRESS with btn_in high, go to LONG, clear cnt and pulse long_pulse, so long_pulse rises exactly LONG_CYCLES cycles after flap_pulse.
REQ-018 SHALL, in PRESS or LONG with btn_in low, go to IDLE, clear cnt and pulse release_pulse.
REQ-019 SHALL give release priority when release and the long threshold occur in the same cycle: release_pulse only, no long_pulse.
REQ-020 SHALL keep flap_pulse, long_pulse, repeat_pulse and release_pulse mutually exclusive in any cycle.
REQ-021 SHALL never let cnt wrap; it is cleared on every state change and bounded by the thresholds.
REQ-022 SHALL update held in the same cycle as the state register.

Reset
REQ-023 SHALL, on rst high, immediately and asynchronously force state IDLE, cnt 0, btn_q 1, and all pulse outputs and held to 0.
REQ-024 SHALL hold these values while rst is high, independent of clk.
REQ-025 SHALL NOT produce flap_pulse after reset deassertion while btn_in remains high; btn_q=1 suppresses the rise.
REQ-026 SHALL, on reset during PRESS or LONG, produce no release_pulse.

Configuration
REQ-027 SHALL use macro AUTO_REPEAT_EN to select the auto-repeat feature.
REQ-028 SHALL, with AUTO_REPEAT_EN defined, increment cnt in LONG while btn_in is high.
REQ-029 SHALL, in that case, when cnt == REPEAT_CYCLES-1, pulse repeat_pulse, clear cnt and remain in LONG.
REQ-030 SHALL give release priority over a repeat pulse in the same cycle.
REQ-031 SHALL, without AUTO_REPEAT_EN, hold cnt at 0 in LONG, tie repeat_pulse to 0 and omit its logic.

Verification (LONG_CYCLES=4, REPEAT_CYCLES=3)
REQ-032 SHALL cover: btn_in high for 2 cycles then low -> flap_pulse at cycle 1, release_pulse at cycle 3, long_pulse never, held high for cycles 1 through 2.
REQ-033 SHALL cover: btn_in held 12 cycles -> flap_pulse at cycle 1, long_pulse at cycle 5, repeat_pulse at 8 and 11 with AUTO_REPEAT_EN or none without, release_pulse after the fall.
REQ-034 SHALL cover: btn_in falls on the exact cycle the long threshold is met -> release_pulse only, no long_pulse.
REQ-035 SHALL cover: btn_in high through rst assert and deassert -> all outputs 0 throughout and no flap_pulse until the input drops and rises again.
REQ-036 SHALL cover: rst asserted mid-LONG between clock edges -> outputs cleared immediately and no release_pulse.
REQ-037 SHALL cover: 1-cycle-low gap between two presses -> two flap_pulses with exactly one release_pulse between them.
